issue_queue: RTL and testbench
==============================

# issue_queue

Parametrised, out-of-order instruction issue queue between rename/dispatch and the execute stage of mips_core.
- Holds up to DEPTH renamed instructions; each entry tracks readiness of two physical source tags.
- Wakes entries on tag broadcasts from up to WAKE_PORTS completing units; issues one ready instruction per cycle, oldest-first.
- Supports full flush on misprediction.

## Interface
- DEPTH, 16: number of entries; power of two, 4..64.
- PHYS_REGS, 64: physical register count; TAG_W = $clog2(PHYS_REGS).
- AL_DEPTH, 32: active-list size; AL_W = $clog2(AL_DEPTH).
- WAKE_PORTS, 2: number of wakeup broadcast ports, 1..4.
- PAYLOAD_W, 96: opaque decoded-instruction payload width (alu_ctl, immediate, branch/mem fields); never interpreted.
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash all entries (mispredict/exception).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept this cycle.
- disp_payload  in  PAYLOAD_W  decoded fields.
- disp_uses_src1, disp_uses_src2  in  1 each  source operand used.
- disp_src1_tag, disp_src2_tag  in  TAG_W each  physical source tags.
- disp_src1_rdy, disp_src2_rdy  in  1 each  busy-table ready bits at dispatch.
- disp_dst_tag  in  TAG_W  physical destination tag.
- disp_al_index  in  AL_W  active-list slot of the instruction.
- wake_valid  in  WAKE_PORTS  per-port broadcast valid.
- wake_tag  in  WAKE_PORTS*TAG_W  packed tags; port p at [p*TAG_W +: TAG_W].
- issue_valid  out  1  an entry is presented.
- issue_ready  in  1  execute accepts.
- issue_payload, issue_src1_tag, issue_src2_tag, issue_dst_tag, issue_al_index  out  as dispatch  fields of issued entry.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Entry state: valid, src1_rdy, src2_rdy, payload, tags, al_index, age row.
- Unused source: ready bit written 1 regardless of tag.
- Dispatch: when disp_valid & disp_ready, write the lowest-index free entry. Source ready = disp_srcN_rdy | ~uses | (any wake_valid[p] with wake_tag[p] == srcN_tag in the same cycle).
- Wakeup: every valid entry sets srcN_rdy when any port matches its tag. Multiple ports matching one tag is legal, same effect.
- Select: candidate = valid & src1_rdy & src2_rdy. Issue the oldest candidate per the age matrix (row i bit j = entry j older than i). issue_valid = any candidate.
- Issue: on issue_valid & issue_ready, the selected entry is freed at posedge. Outputs must hold stable while issue_valid & ~issue_ready, unless an older entry becomes ready; then the selection switches to it.
- Age: on allocation, new entry's row = current valid vector (everything resident is older). Clear column j of all rows when entry j frees.
- disp_ready = count < DEPTH, from registered state only. An entry freed by issue this cycle is not reusable until next cycle.
- Flush: all valid bits cleared at posedge. Dispatch and issue handshakes in the flush cycle are discarded, and issue_valid is forced 0 while flush is high.
- Reset: same as flush; additionally clears ready bits and age matrix.
- Reset values: issue_valid 0, count 0, all issue_* fields 0; disp_ready 0 while rst is high, 1 thereafter.
- Precedence per cycle: rst > flush > (issue free, dispatch write, wakeup), which are independent and concurrent.

## Timing
- Dispatch → earliest issue: 1 cycle (entry written at edge N, issue_valid in cycle N+1 if ready).
- Wakeup in cycle N → dependent entry issue_valid in cycle N+1.
- Select is combinational from registered state. issue_valid is not a function of issue_ready.
- Throughput: 1 dispatch + 1 issue per cycle. When full with simultaneous issue, disp_ready stays 0 that cycle. count changes by −1, 0 or +1.

## Structure
- mips_core_pkg adds: IqTag typedef (logic [TAG_W-1:0]), IqEntry packed struct (valid, src rdy bits, tags, al_index, payload).
- Sub-module iq_age_matrix (DEPTH param): inputs alloc onehot, free onehot, request vector, flush; outputs oldest-grant onehot.
- Free-slot finder: a priority encoder function inside issue_queue.

## Test plan
- Reset, then dispatch 3 instrs with all sources ready, issue_ready=1 → issue in dispatch order, al_index 0,1,2 on consecutive cycles, count returns 0.
- Fill DEPTH=16 entries with src1_tag=5 not ready, issue_ready=1 → disp_ready=0 at count 16 and issue_valid=0. Wake tag 5 → all 16 issue oldest-first, one per cycle.
- Dispatch with src1_tag=9 in the same cycle as wake_tag[1]=9 → entry issues next cycle.
- Entry A (older, not ready) and B (ready); wake A's tag → A issues before B; B follows.
- issue_ready=0 for 3 cycles with one ready entry → issue fields stable; accepted on 4th cycle.
- 8 entries resident, assert flush with disp_valid=1 → count=0 next cycle, dispatched instr dropped, issue_valid=0.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared types for the mips_core issue queue.
// Defaults here seed the issue_queue parameters.
package mips_core_pkg;

  localparam int IQ_DEPTH      = 16;
  localparam int IQ_PHYS_REGS  = 64;
  localparam int IQ_AL_DEPTH   = 32;
  localparam int IQ_WAKE_PORTS = 2;
  localparam int IQ_PAYLOAD_W  = 96;
  localparam int IQ_TAG_W      = $clog2(IQ_PHYS_REGS);
  localparam int IQ_AL_W       = $clog2(IQ_AL_DEPTH);

  typedef logic [IQ_TAG_W-1:0] IqTag;

  typedef struct packed {
    logic                    valid;
    logic                    src1_rdy;
    logic                    src2_rdy;
    IqTag                    src1_tag;
    IqTag                    src2_tag;
    IqTag                    dst_tag;
    logic [IQ_AL_W-1:0]      al_index;
    logic [IQ_PAYLOAD_W-1:0] payload;
  } IqEntry;

endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix: row i bit j set means entry j is older than i.
// Grants the single oldest requesting entry.
module iq_age_matrix #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic [DEPTH-1:0] i_alloc,
  input  logic [DEPTH-1:0] i_free,
  input  logic [DEPTH-1:0] i_valid,
  input  logic [DEPTH-1:0] i_req,
  output logic [DEPTH-1:0] o_grant
);

  logic [DEPTH-1:0] r_row [DEPTH];

  // Entries freed this cycle are excluded from a new row too.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      for (int i = 0; i < DEPTH; i++)
        r_row[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_alloc[i])
          r_row[i] <= i_valid & ~i_free;
        else
          r_row[i] <= r_row[i] & ~i_free;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++)
      o_grant[i] = i_req[i] & ~(|(i_req & r_row[i]));
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue: tag wakeup, oldest-first select,
// one dispatch and one issue per cycle, full flush.
module issue_queue
  import mips_core_pkg::*;
#(
  parameter int DEPTH      = IQ_DEPTH,
  parameter int PHYS_REGS  = IQ_PHYS_REGS,
  parameter int AL_DEPTH   = IQ_AL_DEPTH,
  parameter int WAKE_PORTS = IQ_WAKE_PORTS,
  parameter int PAYLOAD_W  = IQ_PAYLOAD_W,
  localparam int TAG_W     = $clog2(PHYS_REGS),
  localparam int AL_W      = $clog2(AL_DEPTH),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [PAYLOAD_W-1:0]        disp_payload,
  input  logic                        disp_uses_src1,
  input  logic                        disp_uses_src2,
  input  logic [TAG_W-1:0]            disp_src1_tag,
  input  logic [TAG_W-1:0]            disp_src2_tag,
  input  logic                        disp_src1_rdy,
  input  logic                        disp_src2_rdy,
  input  logic [TAG_W-1:0]            disp_dst_tag,
  input  logic [AL_W-1:0]             disp_al_index,
  input  logic [WAKE_PORTS-1:0]       wake_valid,
  input  logic [WAKE_PORTS*TAG_W-1:0] wake_tag,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [PAYLOAD_W-1:0]        issue_payload,
  output logic [TAG_W-1:0]            issue_src1_tag,
  output logic [TAG_W-1:0]            issue_src2_tag,
  output logic [TAG_W-1:0]            issue_dst_tag,
  output logic [AL_W-1:0]             issue_al_index,
  output logic [CNT_W-1:0]            count
);

  typedef struct packed {
    logic                 valid;
    logic                 s1_rdy;
    logic                 s2_rdy;
    logic [TAG_W-1:0]     s1_tag;
    logic [TAG_W-1:0]     s2_tag;
    logic [TAG_W-1:0]     dst_tag;
    logic [AL_W-1:0]      al;
    logic [PAYLOAD_W-1:0] payload;
  } ent_t;

  ent_t             r_ent [DEPTH];
  logic [CNT_W-1:0] r_count;

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_req;
  logic [DEPTH-1:0] w_grant;
  logic [DEPTH-1:0] w_sel;
  logic [DEPTH-1:0] w_free;
  logic [DEPTH-1:0] w_alloc;
  logic [DEPTH-1:0] w_wk1;
  logic [DEPTH-1:0] w_wk2;
  logic             w_fire;
  logic             w_disp_fire;
  logic             w_d1_rdy;
  logic             w_d2_rdy;

  function automatic logic tag_hit(
    input logic [TAG_W-1:0]            t,
    input logic [WAKE_PORTS-1:0]       v,
    input logic [WAKE_PORTS*TAG_W-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++)
      if (v[p] && tags[p*TAG_W +: TAG_W] == t)
        hit = 1'b1;
    return hit;
  endfunction

  // Lowest-index free slot as a onehot vector.
  function automatic logic [DEPTH-1:0] first_free(
    input logic [DEPTH-1:0] v
  );
    logic [DEPTH-1:0] oh;
    oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!v[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    return oh;
  endfunction

  always_comb begin
    w_valid = '0;
    w_req   = '0;
    w_wk1   = '0;
    w_wk2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_req[i]   = r_ent[i].valid & r_ent[i].s1_rdy
                 & r_ent[i].s2_rdy;
      w_wk1[i]   = tag_hit(r_ent[i].s1_tag,
                           wake_valid, wake_tag);
      w_wk2[i]   = tag_hit(r_ent[i].s2_tag,
                           wake_valid, wake_tag);
    end
  end

  iq_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_alloc (w_alloc),
    .i_free  (w_free),
    .i_valid (w_valid),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  assign w_sel       = (rst || flush) ? '0 : w_grant;
  assign issue_valid = |w_sel;
  assign w_fire      = issue_valid & issue_ready;
  assign w_free      = w_fire ? w_sel : '0;

  assign disp_ready  = ~rst & (r_count < CNT_W'(DEPTH));
  assign w_disp_fire = disp_valid & disp_ready & ~flush;
  assign w_alloc     = w_disp_fire ? first_free(w_valid) : '0;
  assign count       = r_count;

  assign w_d1_rdy = disp_src1_rdy | ~disp_uses_src1
                  | tag_hit(disp_src1_tag, wake_valid, wake_tag);
  assign w_d2_rdy = disp_src2_rdy | ~disp_uses_src2
                  | tag_hit(disp_src2_tag, wake_valid, wake_tag);

  always_comb begin
    issue_payload  = '0;
    issue_src1_tag = '0;
    issue_src2_tag = '0;
    issue_dst_tag  = '0;
    issue_al_index = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_sel[i]) begin
        issue_payload  = issue_payload  | r_ent[i].payload;
        issue_src1_tag = issue_src1_tag | r_ent[i].s1_tag;
        issue_src2_tag = issue_src2_tag | r_ent[i].s2_tag;
        issue_dst_tag  = issue_dst_tag  | r_ent[i].dst_tag;
        issue_al_index = issue_al_index | r_ent[i].al;
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i].valid  <= 1'b0;
        r_ent[i].s1_rdy <= 1'b0;
        r_ent[i].s2_rdy <= 1'b0;
      end
      r_count <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++)
        r_ent[i].valid <= 1'b0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc[i]) begin
          r_ent[i].valid   <= 1'b1;
          r_ent[i].s1_rdy  <= w_d1_rdy;
          r_ent[i].s2_rdy  <= w_d2_rdy;
          r_ent[i].s1_tag  <= disp_src1_tag;
          r_ent[i].s2_tag  <= disp_src2_tag;
          r_ent[i].dst_tag <= disp_dst_tag;
          r_ent[i].al      <= disp_al_index;
          r_ent[i].payload <= disp_payload;
        end else begin
          if (w_free[i])
            r_ent[i].valid <= 1'b0;
          if (w_wk1[i])
            r_ent[i].s1_rdy <= 1'b1;
          if (w_wk2[i])
            r_ent[i].s2_rdy <= 1'b1;
        end
      end
      r_count <= r_count + CNT_W'(w_disp_fire)
                         - CNT_W'(w_fire);
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: age-ordered queue model checked every
// cycle, directed scenarios with literal checks, random traffic.
module tb_issue_queue;

  localparam int DEPTH = 16;
  localparam int WP    = 2;
  localparam int TW    = 6;
  localparam int AW    = 5;
  localparam int PW    = 96;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          disp_valid = 1'b0;
  logic          disp_ready;
  logic [PW-1:0] disp_payload = '0;
  logic          disp_uses_src1 = 1'b0;
  logic          disp_uses_src2 = 1'b0;
  logic [TW-1:0] disp_src1_tag = '0;
  logic [TW-1:0] disp_src2_tag = '0;
  logic          disp_src1_rdy = 1'b0;
  logic          disp_src2_rdy = 1'b0;
  logic [TW-1:0] disp_dst_tag = '0;
  logic [AW-1:0] disp_al_index = '0;
  logic [WP-1:0] wake_valid = '0;
  logic [WP*TW-1:0] wake_tag = '0;
  logic          issue_valid;
  logic          issue_ready = 1'b0;
  logic [PW-1:0] issue_payload;
  logic [TW-1:0] issue_src1_tag;
  logic [TW-1:0] issue_src2_tag;
  logic [TW-1:0] issue_dst_tag;
  logic [AW-1:0] issue_al_index;
  logic [4:0]    count;

  int n_checks = 0;
  int n_errs   = 0;
  logic [PW-1:0] last_pl;

  issue_queue dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .disp_valid     (disp_valid),
    .disp_ready     (disp_ready),
    .disp_payload   (disp_payload),
    .disp_uses_src1 (disp_uses_src1),
    .disp_uses_src2 (disp_uses_src2),
    .disp_src1_tag  (disp_src1_tag),
    .disp_src2_tag  (disp_src2_tag),
    .disp_src1_rdy  (disp_src1_rdy),
    .disp_src2_rdy  (disp_src2_rdy),
    .disp_dst_tag   (disp_dst_tag),
    .disp_al_index  (disp_al_index),
    .wake_valid     (wake_valid),
    .wake_tag       (wake_tag),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_payload  (issue_payload),
    .issue_src1_tag (issue_src1_tag),
    .issue_src2_tag (issue_src2_tag),
    .issue_dst_tag  (issue_dst_tag),
    .issue_al_index (issue_al_index),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [PW-1:0] pl;
    logic [TW-1:0] t1;
    logic [TW-1:0] t2;
    logic [TW-1:0] dst;
    logic [AW-1:0] al;
    bit            r1;
    bit            r2;
  } m_t;

  m_t q[$];

  function automatic bit wmatch(input logic [TW-1:0] t);
    bit h = 0;
    for (int p = 0; p < WP; p++)
      if (wake_valid[p] && wake_tag[p*TW +: TW] == t)
        h = 1;
    return h;
  endfunction

  // Model: q holds resident entries in dispatch (age) order.
  always @(negedge clk) begin
    int  idx;
    bit  exp_iv;
    bit  exp_dr;
    m_t  e;
    idx = -1;
    for (int i = 0; i < q.size(); i++)
      if (idx < 0 && q[i].r1 && q[i].r2)
        idx = i;
    exp_iv = (idx >= 0) && !flush && !rst;
    exp_dr = !rst && (q.size() < DEPTH);
    chk("m_issue_valid", issue_valid, exp_iv);
    chk("m_disp_ready", disp_ready, exp_dr);
    chk("m_count", count, q.size());
    if (exp_iv) begin
      chk("m_payload", issue_payload, q[idx].pl);
      chk("m_src1", issue_src1_tag, q[idx].t1);
      chk("m_src2", issue_src2_tag, q[idx].t2);
      chk("m_dst", issue_dst_tag, q[idx].dst);
      chk("m_al", issue_al_index, q[idx].al);
    end else if (rst) begin
      chk("m_rst_payload", issue_payload, 0);
      chk("m_rst_al", issue_al_index, 0);
    end
    if (rst || flush) begin
      q.delete();
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        if (wmatch(q[i].t1)) q[i].r1 = 1;
        if (wmatch(q[i].t2)) q[i].r2 = 1;
      end
      if (exp_iv && issue_ready)
        q.delete(idx);
      if (disp_valid && exp_dr) begin
        e.pl  = disp_payload;
        e.t1  = disp_src1_tag;
        e.t2  = disp_src2_tag;
        e.dst = disp_dst_tag;
        e.al  = disp_al_index;
        e.r1  = disp_src1_rdy || !disp_uses_src1
                || wmatch(disp_src1_tag);
        e.r2  = disp_src2_rdy || !disp_uses_src2
                || wmatch(disp_src2_tag);
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input bit v, input bit u1,
                      input int t1, input bit r1,
                      input bit u2, input int t2,
                      input bit r2, input int al);
    disp_valid     = v;
    disp_uses_src1 = u1;
    disp_src1_tag  = TW'(t1);
    disp_src1_rdy  = r1;
    disp_uses_src2 = u2;
    disp_src2_tag  = TW'(t2);
    disp_src2_rdy  = r2;
    disp_al_index  = AW'(al);
    disp_dst_tag   = TW'($urandom);
    disp_payload   = {$urandom, $urandom, $urandom};
    last_pl        = disp_payload;
  endtask

  task automatic nodisp();
    disp_valid = 1'b0;
  endtask

  task automatic wake(input int p, input int t);
    wake_valid          = '0;
    wake_tag            = '0;
    wake_valid[p]       = 1'b1;
    wake_tag[p*TW +: TW] = TW'(t);
  endtask

  initial begin
    #200000;
    n_errs++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    repeat (3) step();
    chk("rst_disp_ready", disp_ready, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_payload", issue_payload, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_disp_ready", disp_ready, 1);
    step();

    // Three ready instructions issue in order.
    issue_ready = 1'b1;
    disp(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    disp(1, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("t1_al0", issue_al_index, 0);
    step();
    disp(1, 0, 0, 0, 0, 0, 0, 2);
    #1 chk("t1_al1", issue_al_index, 1);
    step();
    nodisp();
    #1 chk("t1_al2", issue_al_index, 2);
    chk("t1_iv2", issue_valid, 1);
    step();
    #1 chk("t1_count0", count, 0);
    chk("t1_iv_end", issue_valid, 0);

    // Fill with entries waiting on tag 5, then wake.
    for (int i = 0; i < DEPTH; i++) begin
      disp(1, 1, 5, 0, 0, 0, 0, i);
      step();
    end
    nodisp();
    #1 chk("t2_full_count", count, 16);
    chk("t2_full_ready", disp_ready, 0);
    chk("t2_full_iv", issue_valid, 0);
    wake(0, 5);
    step();
    wake_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      #1 chk("t2_order", issue_al_index, i);
      step();
    end
    #1 chk("t2_empty", count, 0);

    // Same-cycle wakeup at dispatch.
    disp(1, 1, 9, 0, 0, 0, 0, 3);
    wake(1, 9);
    step();
    nodisp();
    wake_valid = '0;
    #1 chk("t3_iv", issue_valid, 1);
    chk("t3_al", issue_al_index, 3);
    step();
    #1 chk("t3_count", count, 0);

    // Older entry woken overtakes a younger ready one.
    issue_ready = 1'b0;
    disp(1, 1, 12, 0, 1, 13, 1, 20);
    step();
    disp(1, 0, 0, 0, 0, 0, 0, 21);
    step();
    nodisp();
    wake(0, 12);
    #1 chk("t4_b_first", issue_al_index, 21);
    step();
    wake_valid = '0;
    issue_ready = 1'b1;
    #1 chk("t4_a", issue_al_index, 20);
    step();
    #1 chk("t4_b", issue_al_index, 21);
    step();
    #1 chk("t4_count", count, 0);

    // Stall keeps the presented entry stable.
    issue_ready = 1'b0;
    disp(1, 0, 0, 0, 0, 0, 0, 7);
    step();
    nodisp();
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_iv", issue_valid, 1);
      chk("t5_al", issue_al_index, 7);
      chk("t5_pl", issue_payload, last_pl);
      step();
    end
    issue_ready = 1'b1;
    #1 chk("t5_accept_pl", issue_payload, last_pl);
    step();
    #1 chk("t5_count", count, 0);

    // Flush drops residents and the same-cycle dispatch.
    for (int i = 0; i < 8; i++) begin
      disp(1, 1, 30, 0, 0, 0, 0, i);
      step();
    end
    disp(1, 0, 0, 0, 0, 0, 0, 9);
    flush = 1'b1;
    #1 chk("t6_count8", count, 8);
    chk("t6_iv_flush", issue_valid, 0);
    step();
    flush = 1'b0;
    nodisp();
    #1 chk("t6_count0", count, 0);
    chk("t6_iv", issue_valid, 0);
    step();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      disp($urandom_range(0, 9) < 6,
           $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 31));
      for (int p = 0; p < WP; p++) begin
        wake_valid[p] = $urandom_range(0, 2) == 0;
        wake_tag[p*TW +: TW] = TW'($urandom_range(0, 15));
      end
      issue_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 99) == 0;
      rst   = $urandom_range(0, 199) == 0;
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
    nodisp();
    wake_valid = '0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
